// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC and moves one instruction at a time from imem to decode.
// Optional FETCH_PERF_EN adds saturating fetched/squashed/stall counters.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [7:0]  MAX_WAIT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_valid,
    input  logic [15:0] imem_data,
    input  logic        dec_stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        halt,
    output logic        inst_valid,
    output logic [15:0] inst,
    output logic [15:0] inst_pc,
    output logic [15:0] pc_inc,
    output logic        pc_overflow,
    output logic        halted,
    output logic        imem_timeout
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0] perf_fetched,
    output logic [15:0] perf_squashed,
    output logic [15:0] perf_stall
`endif
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, DRAIN, HALT} state_t;

    state_t      state;
    logic [15:0] pc;
    logic        halt_pend;
    logic [7:0]  wait_cnt;
    logic [16:0] pc_sum;
    logic        waiting;

    assign pc_sum     = {1'b0, pc} + 17'd2;
    assign waiting    = (state == WAIT) || (state == DRAIN);
    assign inst_valid = (state == OUT) && !redirect;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            halt_pend    <= 1'b0;
            wait_cnt     <= 8'd0;
            imem_req     <= 1'b0;
            imem_addr    <= 16'h0000;
            inst         <= 16'h0000;
            inst_pc      <= 16'h0000;
            pc_inc       <= 16'h0000;
            pc_overflow  <= 1'b0;
            halted       <= 1'b0;
            imem_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state     <= REQ;
                    imem_req  <= 1'b1;
                    imem_addr <= pc;
                end
                REQ: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                        if (imem_ready) begin
                            // the old request is already in flight; its response must be dropped
                            state    <= DRAIN;
                            imem_req <= 1'b0;
                        end else begin
                            imem_addr <= redirect_pc;
                        end
                    end else if (imem_ready) begin
                        state    <= WAIT;
                        imem_req <= 1'b0;
                        if (halt)
                            halt_pend <= 1'b1;
                    end else if (halt) begin
                        state    <= HALT;
                        imem_req <= 1'b0;
                        halted   <= 1'b1;
                    end
                end
                WAIT: begin
                    if (halt)
                        halt_pend <= 1'b1;
                    if (redirect) begin
                        pc <= redirect_pc;
                        if (!imem_valid) begin
                            state <= DRAIN;
                        end else if (halt_pend) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            state     <= REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= redirect_pc;
                        end
                    end else if (imem_valid) begin
                        if (halt_pend) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            state                 <= OUT;
                            inst                  <= imem_data;
                            inst_pc               <= pc;
                            {pc_overflow, pc_inc} <= pc_sum;
                        end
                    end
                end
                DRAIN: begin
                    if (halt)
                        halt_pend <= 1'b1;
                    if (redirect)
                        pc <= redirect_pc;
                    if (imem_valid) begin
                        if (halt_pend) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            state     <= REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= redirect ? redirect_pc : pc;
                        end
                    end
                end
                OUT: begin
                    if (redirect) begin
                        pc        <= redirect_pc;
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= redirect_pc;
                    end else if (!dec_stall) begin
                        pc <= pc_inc;
                        if (halt || halt_pend) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            state     <= REQ;
                            imem_req  <= 1'b1;
                            imem_addr <= pc_inc;
                        end
                    end
                end
                HALT: begin
                    imem_req <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase

            // the wait budget spans WAIT and DRAIN together; only a response ends it
            if (waiting && !imem_valid) begin
                if (wait_cnt != 8'hFF)
                    wait_cnt <= wait_cnt + 8'd1;
                if (({1'b0, wait_cnt} + 9'd1) >= {1'b0, MAX_WAIT})
                    imem_timeout <= 1'b1;
            end else begin
                wait_cnt <= 8'd0;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic fetch_ev;
    logic squash_ev;
    logic stall_ev;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign fetch_ev  = inst_valid && !dec_stall;
    assign squash_ev = ((state == WAIT) && imem_valid && (redirect || halt_pend)) ||
                       ((state == DRAIN) && imem_valid) ||
                       ((state == OUT) && redirect);
    assign stall_ev  = (state == OUT) && dec_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched  <= 16'h0000;
            perf_squashed <= 16'h0000;
            perf_stall    <= 16'h0000;
        end else begin
            if (fetch_ev)
                perf_fetched <= sat_inc(perf_fetched);
            if (squash_ev)
                perf_squashed <= sat_inc(perf_squashed);
            if (stall_ev)
                perf_stall <= sat_inc(perf_stall);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; a second instance with RESET_PC = 16'hFFFE covers PC wrap.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ready, imem_valid, dec_stall, redirect, halt;
    logic [15:0] imem_data, redirect_pc;

    logic        imem_req, inst_valid, pc_overflow, halted, imem_timeout;
    logic [15:0] imem_addr, inst, inst_pc, pc_inc;
    logic        d2_imem_req, d2_inst_valid, d2_pc_overflow, d2_halted, d2_imem_timeout;
    logic [15:0] d2_imem_addr, d2_inst, d2_inst_pc, d2_pc_inc;
`ifdef FETCH_PERF_EN
    logic [15:0] pf_f, pf_s, pf_t, pf2_f, pf2_s, pf2_t;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_valid(imem_valid), .imem_data(imem_data),
        .dec_stall(dec_stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .pc_inc(pc_inc),
        .pc_overflow(pc_overflow), .halted(halted), .imem_timeout(imem_timeout)
`ifdef FETCH_PERF_EN
        , .perf_fetched(pf_f), .perf_squashed(pf_s), .perf_stall(pf_t)
`endif
    );

    fetch_sequencer #(.RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .rst(rst), .imem_req(d2_imem_req), .imem_addr(d2_imem_addr),
        .imem_ready(imem_ready), .imem_valid(imem_valid), .imem_data(imem_data),
        .dec_stall(dec_stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .inst_valid(d2_inst_valid), .inst(d2_inst), .inst_pc(d2_inst_pc), .pc_inc(d2_pc_inc),
        .pc_overflow(d2_pc_overflow), .halted(d2_halted), .imem_timeout(d2_imem_timeout)
`ifdef FETCH_PERF_EN
        , .perf_fetched(pf2_f), .perf_squashed(pf2_s), .perf_stall(pf2_t)
`endif
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start();
        rst = 1'b0; imem_ready = 1'b1; imem_valid = 1'b0; imem_data = 16'h0000;
        dec_stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; halt = 1'b0;
        step(2);
        rst = 1'b1;
    endtask

    // request at edge A, accept at B, response sampled at D (2-cycle latency)
    task automatic fetch_to_out(input logic [15:0] data);
        step(3);
        imem_valid = 1'b1; imem_data = data;
        step(1);
        imem_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; imem_ready = 1'b1; imem_valid = 1'b0; imem_data = 16'h0000;
        dec_stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; halt = 1'b0;
        step(2);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL rst_addr got=%h exp=0000", imem_addr); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_ivalid got=%b exp=0", inst_valid); end
        total++; if ({halted, imem_timeout, pc_overflow} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {halted, imem_timeout, pc_overflow}); end
        total++; if (d2_imem_addr !== 16'h0000) begin bad++; $display("FAIL rst_addr2 got=%h exp=0000", d2_imem_addr); end
        rst = 1'b1;
        fetch_to_out(16'h9999);
        step(1);
        rst = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000) begin bad++; $display("FAIL midrst_req got=%b/%h exp=0/0000", imem_req, imem_addr); end
        total++; if (inst !== 16'h0000 || inst_pc !== 16'h0000) begin bad++; $display("FAIL midrst_inst got=%h/%h exp=0000/0000", inst, inst_pc); end
        total++; if (pc_inc !== 16'h0000) begin bad++; $display("FAIL midrst_pcinc got=%h exp=0000", pc_inc); end
    endtask

    task automatic test_basic();
        start();
        step(1);
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin bad++; $display("FAIL basic_req0 got=%b/%h exp=1/0000", imem_req, imem_addr); end
        step(1);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL basic_reqdrop got=%b exp=0", imem_req); end
        step(1);
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid got=%b exp=0", inst_valid); end
        imem_valid = 1'b1; imem_data = 16'h1111;
        step(1);
        imem_valid = 1'b0;
        total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL basic_ivalid got=%b exp=1", inst_valid); end
        total++; if (inst !== 16'h1111 || inst_pc !== 16'h0000) begin bad++; $display("FAIL basic_inst got=%h/%h exp=1111/0000", inst, inst_pc); end
        total++; if (pc_inc !== 16'h0002 || pc_overflow !== 1'b0) begin bad++; $display("FAIL basic_pcinc got=%h/%b exp=0002/0", pc_inc, pc_overflow); end
        step(1);
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b exp=0", inst_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin bad++; $display("FAIL basic_req1 got=%b/%h exp=1/0002", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_wait();
        start();
        step(2);
        redirect = 1'b1; redirect_pc = 16'h0100;
        step(1);
        redirect = 1'b0;
        imem_valid = 1'b1; imem_data = 16'hDEAD;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rdw_ivalid0 got=%b exp=0", inst_valid); end
        step(1);
        imem_valid = 1'b0;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rdw_ivalid1 got=%b exp=0", inst_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin bad++; $display("FAIL rdw_addr got=%b/%h exp=1/0100", imem_req, imem_addr); end
        total++; if (inst === 16'hDEAD) begin bad++; $display("FAIL rdw_stale got=%h exp=not_dead", inst); end
    endtask

    task automatic test_redirect_out();
        start();
        fetch_to_out(16'h5555);
        redirect = 1'b1; redirect_pc = 16'h0201;
        #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rdo_mask got=%b exp=0", inst_valid); end
        step(1);
        redirect = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0201) begin bad++; $display("FAIL rdo_addr got=%b/%h exp=1/0201", imem_req, imem_addr); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rdo_ivalid got=%b exp=0", inst_valid); end
    endtask

    task automatic test_overflow();
        start();
        step(1);
        total++; if (d2_imem_addr !== 16'hFFFE) begin bad++; $display("FAIL ovf_addr0 got=%h exp=fffe", d2_imem_addr); end
        step(2);
        imem_valid = 1'b1; imem_data = 16'h7777;
        step(1);
        imem_valid = 1'b0;
        total++; if (d2_inst_pc !== 16'hFFFE) begin bad++; $display("FAIL ovf_instpc got=%h exp=fffe", d2_inst_pc); end
        total++; if (d2_pc_inc !== 16'h0000 || d2_pc_overflow !== 1'b1) begin bad++; $display("FAIL ovf_pcinc got=%h/%b exp=0000/1", d2_pc_inc, d2_pc_overflow); end
        step(1);
        total++; if (d2_imem_req !== 1'b1 || d2_imem_addr !== 16'h0000) begin bad++; $display("FAIL ovf_wrap got=%b/%h exp=1/0000", d2_imem_req, d2_imem_addr); end
    endtask

    task automatic test_stall();
        start();
        fetch_to_out(16'h2222);
        dec_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            total++;
            if (inst_valid !== 1'b1 || inst !== 16'h2222 || inst_pc !== 16'h0000 || imem_req !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold%0d got=%b/%h/%h/%b exp=1/2222/0000/0", i, inst_valid, inst, inst_pc, imem_req);
            end
        end
        dec_stall = 1'b0;
        step(1);
        total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0002 || inst_valid !== 1'b0) begin bad++; $display("FAIL stall_xfer got=%b/%h/%b exp=1/0002/0", imem_req, imem_addr, inst_valid); end
    endtask

    task automatic test_halt();
        start();
        step(2);
        halt = 1'b1;
        step(1);
        halt = 1'b0;
        imem_valid = 1'b1; imem_data = 16'h3333;
        step(1);
        imem_valid = 1'b0;
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b exp=1", halted); end
        total++; if (inst_valid !== 1'b0 || inst !== 16'h0000) begin bad++; $display("FAIL halt_discard got=%b/%h exp=0/0000", inst_valid, inst); end
        for (int i = 0; i < 20; i++) begin
            step(1);
            total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL halt_req%0d got=%b exp=0", i, imem_req); end
        end
        redirect = 1'b1; redirect_pc = 16'h0400;
        step(1);
        redirect = 1'b0;
        step(2);
        total++; if (imem_req !== 1'b0 || halted !== 1'b1) begin bad++; $display("FAIL halt_redirect got=%b/%b exp=0/1", imem_req, halted); end
    endtask

    task automatic test_timeout();
        start();
        step(2);
        step(254);
        total++; if (imem_timeout !== 1'b0) begin bad++; $display("FAIL to_early got=%b exp=0", imem_timeout); end
        step(1);
        total++; if (imem_timeout !== 1'b1) begin bad++; $display("FAIL to_set got=%b exp=1", imem_timeout); end
        step(45);
        total++; if (imem_timeout !== 1'b1 || inst_valid !== 1'b0) begin bad++; $display("FAIL to_sticky got=%b/%b exp=1/0", imem_timeout, inst_valid); end
        imem_valid = 1'b1; imem_data = 16'h4444;
        step(1);
        imem_valid = 1'b0;
        total++; if (inst_valid !== 1'b1 || inst !== 16'h4444 || inst_pc !== 16'h0000) begin bad++; $display("FAIL to_late got=%b/%h/%h exp=1/4444/0000", inst_valid, inst, inst_pc); end
        step(1);
        total++; if (imem_addr !== 16'h0002 || imem_timeout !== 1'b1) begin bad++; $display("FAIL to_next got=%h/%b exp=0002/1", imem_addr, imem_timeout); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_redirect_wait();
        test_redirect_out();
        test_overflow();
        test_stall();
        test_halt();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controller that owns the program counter and sequences instruction fetch over a request/response instruction-memory port.
- Presents one instruction at a time to decode with a valid/stall handshake.
- Applies branch/jump redirects, squashes stale responses, and stops fetch on halt.
- Sits between the instruction memory and the decode stage. Supplies the PC+2 value and the PC-overflow flag used by the fetch stage.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- MAX_WAIT, 255, cycle limit for the imem_valid wait before imem_timeout is raised. Width is 8 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-low
- imem_req  out  1  request valid; registered
- imem_addr  out  16  request address (current PC); registered
- imem_ready  in  1  memory accepts the request this cycle
- imem_valid  in  1  response data valid
- imem_data  in  16  response instruction word
- dec_stall  in  1  decode cannot accept this cycle
- redirect  in  1  branch/jump taken
- redirect_pc  in  16  redirect target
- halt  in  1  stop fetching (HALT instruction decoded)
- inst_valid  out  1  inst/inst_pc valid to decode
- inst  out  16  fetched instruction
- inst_pc  out  16  address of inst
- pc_inc  out  16  inst_pc + 2, low 16 bits
- pc_overflow  out  1  carry out of inst_pc + 2
- halted  out  1  fetch stopped
- imem_timeout  out  1  sticky; wait exceeded MAX_WAIT

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, pc = RESET_PC.
  - All outputs 0, including imem_addr, halted, imem_timeout; halt_pend = 0.
- States: IDLE, REQ, WAIT, OUT, DRAIN, HALT.
- Only one request is outstanding at a time. A request is accepted on a cycle where imem_req = 1 and imem_ready = 1. The response arrives with imem_valid no earlier than the next cycle.
- IDLE: next cycle goes to REQ. imem_req = 1 and imem_addr = pc while in REQ.
- REQ:
  - redirect & imem_ready: old request is accepted; pc <= redirect_pc; go DRAIN.
  - redirect only: pc <= redirect_pc; stay REQ. The new address appears the next cycle.
  - halt (no redirect) & !imem_ready: go HALT.
  - halt (no redirect) & imem_ready: halt_pend <= 1; go WAIT.
  - imem_ready otherwise: go WAIT.
- WAIT:
  - On imem_valid: latch inst <= imem_data and inst_pc <= pc; go OUT. If halt_pend is set, go HALT instead and discard the data.
  - redirect in WAIT: pc <= redirect_pc; go DRAIN. If redirect and imem_valid occur together, the data is discarded and the next state is REQ.
  - halt in WAIT: halt_pend <= 1.
  - Wait counter: increments each WAIT/DRAIN cycle and clears on leaving. When it reaches MAX_WAIT, imem_timeout <= 1 (sticky until reset); the state machine keeps waiting.
- DRAIN: discards the next imem_valid, then goes REQ (or HALT if halt_pend is set).
- OUT:
  - inst_valid = 1 & !redirect (combinational mask).
  - Transfer occurs when inst_valid & !dec_stall. On transfer: pc <= inst_pc + 2 with wrap; go REQ (or HALT if halt or halt_pend).
  - redirect in OUT: instruction dropped; pc <= redirect_pc; go REQ. Redirect has priority over halt and stall.
  - dec_stall: hold all outputs; stay OUT.
- HALT: halted = 1, imem_req = 0. Only reset leaves this state. redirect and halt are ignored.
- Arithmetic:
  - pc_inc / pc_overflow = 17-bit sum inst_pc + 2. Example: inst_pc 16'hFFFE gives pc_inc 16'h0000 and pc_overflow 1.
  - Sequential pc wraps to 16'h0000.
  - Odd PCs are legal; no alignment check.
- Outputs inst, inst_pc, pc_inc and pc_overflow are stable for the whole time OUT is held.
- Reset mid-operation clears all state. An imem_valid that arrives after reset while in IDLE or REQ is ignored.

Optional Feature:
- FETCH_PERF_EN defined adds three 16-bit saturating counters, each with an output port:
  - perf_fetched: transfers.
  - perf_squashed: data discarded in DRAIN/WAIT or dropped in OUT.
  - perf_stall: OUT cycles with dec_stall high.
- All counters reset to 0.
- Undefined: neither the ports nor the logic exist; all other behaviour is identical.

Test Plan:
- Reset release, imem_ready = 1, 2-cycle latency returning 16'h1111, dec_stall = 0 -> imem_addr 0x0000 then 0x0002. inst_valid pulses with inst 16'h1111, inst_pc 0x0000, pc_inc 0x0002, pc_overflow 0.
- redirect_pc = 16'h0100 asserted in WAIT -> stale response discarded, inst_valid stays 0, next imem_addr = 0x0100.
- RESET_PC = 16'hFFFE, fetch completes -> pc_overflow 1, pc_inc 0x0000, next imem_addr 0x0000.
- dec_stall high for 3 cycles in OUT -> inst and inst_pc held, no new imem_req. The transfer occurs on the 4th cycle.
- halt during WAIT -> response discarded, halted = 1, imem_req stays 0 for 20 cycles; a later redirect is ignored.
- imem_valid withheld for 300 cycles (MAX_WAIT = 255) -> imem_timeout = 1 from cycle 255 and stays set. A late response is then accepted normally.
